// File: rtl/lc3_run_ctrl_if.sv
// Run-controller bus: start/observe signals from the bench or board side and
// run status/statistics back from lc3_run_ctrl. The controller uses the slave
// modport; whoever drives the run uses master.
interface lc3_run_ctrl_if #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TRACE_DEPTH = 8
);
  localparam int unsigned IDX_W = $clog2(TRACE_DEPTH);

  logic             start;
  logic             ir_ld;
  logic [15:0]      ir;
  logic [15:0]      pc;
  logic [IDX_W-1:0] trace_idx;

  logic             core_rst;
  logic             running;
  logic             halted;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic [15:0]      trace_pc;

  modport master (
    output start, ir_ld, ir, pc, trace_idx,
    input  core_rst, running, halted, timeout, cycle_cnt, instr_cnt, trace_pc
  );

  modport slave (
    input  start, ir_ld, ir, pc, trace_idx,
    output core_rst, running, halted, timeout, cycle_cnt, instr_cnt, trace_pc
  );
endinterface

// File: rtl/lc3_run_ctrl.sv
// LC-3 run controller: sequences the core reset after start, counts RUN cycles
// and fetched instructions, stops on HALT (F025) or watchdog expiry.
// Optional PC trace buffer is built when LC3_TRACE_EN is defined; otherwise
// trace_pc reads 0.
module lc3_run_ctrl #(
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TRACE_DEPTH    = 8
) (
  input logic           clk,
  input logic           rst,
  lc3_run_ctrl_if.slave bus
);
  localparam int unsigned RCNT_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCNT_W-1:0] RST_LOAD = RCNT_W'(RST_CYCLES - 1);
  // Wraps when TIMEOUT_CYCLES is 0, but WD_EN masks it off in that case.
  localparam logic [CNT_W-1:0]  WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit                WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0]       HALT_OP  = 16'hF025;

  typedef enum logic [1:0] {StIdle, StReset, StRun, StDone} state_e;

  state_e             state_q;
  logic [RCNT_W-1:0]  rst_cnt_q;
  logic               core_rst_q;
  logic               running_q;
  logic               halted_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   cycle_cnt_q;
  logic [CNT_W-1:0]   instr_cnt_q;

  logic halt_hit;
  logic wd_hit;
  logic run_clear;
  logic trace_wr;

  assign halt_hit  = bus.ir_ld && (bus.ir == HALT_OP);
  assign wd_hit    = WD_EN && (cycle_cnt_q == WD_LAST);
  assign run_clear = ((state_q == StIdle) || (state_q == StDone)) && bus.start;
  assign trace_wr  = (state_q == StRun) && bus.ir_ld;

  // Run sequencer with registered status outputs and saturating counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rst_cnt_q   <= '0;
      core_rst_q  <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_q     <= StReset;
            rst_cnt_q   <= RST_LOAD;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
          end
        end
        StReset: begin
          if (rst_cnt_q == '0) begin
            state_q    <= StRun;
            core_rst_q <= 1'b1;
            running_q  <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q - 1'b1;
          end
        end
        StRun: begin
          // The terminating cycle and the HALT fetch itself are both counted.
          if (cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + 1'b1;
          if (bus.ir_ld && (instr_cnt_q != '1)) instr_cnt_q <= instr_cnt_q + 1'b1;
          if (halt_hit) begin
            state_q    <= StDone;
            halted_q   <= 1'b1;
            core_rst_q <= 1'b0;
            running_q  <= 1'b0;
          end else if (wd_hit) begin
            state_q    <= StDone;
            timeout_q  <= 1'b1;
            core_rst_q <= 1'b0;
            running_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.core_rst  = core_rst_q;
  assign bus.running   = running_q;
  assign bus.halted    = halted_q;
  assign bus.timeout   = timeout_q;
  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.instr_cnt = instr_cnt_q;

`ifdef LC3_TRACE_EN
  localparam int unsigned IDX_W  = $clog2(TRACE_DEPTH);
  localparam int unsigned FILL_W = IDX_W + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TRACE_DEPTH);

  logic [15:0]       trace_mem [TRACE_DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [FILL_W-1:0] fill_q;
  logic [IDX_W-1:0]  rd_ptr;
  logic [15:0]       trace_pc;

  // Write pointer and fill level; fill saturates at depth so stale reads mask to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (run_clear) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (trace_wr) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
    end
  end

  // Trace storage; contents beyond the fill level are never visible.
  always_ff @(posedge clk) begin
    if (trace_wr) trace_mem[wr_ptr_q] <= bus.pc;
  end

  // Index 0 is the most recent entry, one behind the write pointer.
  always_comb begin
    rd_ptr   = wr_ptr_q - IDX_W'(1) - bus.trace_idx;
    trace_pc = 16'h0000;
    if ({1'b0, bus.trace_idx} < fill_q) trace_pc = trace_mem[rd_ptr];
  end

  assign bus.trace_pc = trace_pc;
`else
  logic unused_trace;
  assign unused_trace = (^{bus.trace_idx, bus.pc, run_clear, trace_wr}) ^ (TRACE_DEPTH == 0);
  assign bus.trace_pc = 16'h0000;
`endif

endmodule

// File: tb/tb_lc3_run_ctrl.sv
// Directed bench for lc3_run_ctrl. dut_a: RST_CYCLES=4, TIMEOUT_CYCLES=20,
// TRACE_DEPTH=4. dut_b: CNT_W=4, watchdog off, for saturation.
module tb_lc3_run_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lc3_run_ctrl_if #(.CNT_W(32), .TRACE_DEPTH(4)) bus_a ();
  lc3_run_ctrl_if #(.CNT_W(4),  .TRACE_DEPTH(2)) bus_b ();

  lc3_run_ctrl #(
    .RST_CYCLES(4), .TIMEOUT_CYCLES(20), .CNT_W(32), .TRACE_DEPTH(4)
  ) dut_a (
    .clk(clk),
    .rst(rst_n),
    .bus(bus_a)
  );

  lc3_run_ctrl #(
    .RST_CYCLES(2), .TIMEOUT_CYCLES(0), .CNT_W(4), .TRACE_DEPTH(2)
  ) dut_b (
    .clk(clk),
    .rst(rst_n),
    .bus(bus_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on dut_a and walk through its 4 reset cycles into RUN.
  task automatic start_a();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    if (bus_a.core_rst !== 1'b0 || bus_a.running !== 1'b0 || bus_a.halted !== 1'b0 ||
        bus_a.timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags_a got=%b%b%b%b exp=0000", bus_a.core_rst, bus_a.running,
               bus_a.halted, bus_a.timeout);
    end
    checks++;
    if (bus_a.cycle_cnt !== 32'd0 || bus_a.instr_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_cnt_a got=%0d/%0d exp=0/0", bus_a.cycle_cnt, bus_a.instr_cnt);
    end
    checks++;
    if (bus_b.core_rst !== 1'b0 || bus_b.cycle_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_b got=%b/%0d exp=0/0", bus_b.core_rst, bus_b.cycle_cnt);
    end
    checks++;
  endtask

  task automatic test_startup();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus_a.core_rst !== 1'b0 || bus_a.running !== 1'b0) begin
        failures++;
        $display("FAIL startup_low[%0d] got=%b%b exp=00", i, bus_a.core_rst, bus_a.running);
      end
      checks++;
      step();
    end
    if (bus_a.core_rst !== 1'b1 || bus_a.running !== 1'b1 || bus_a.cycle_cnt !== 32'd0) begin
      failures++;
      $display("FAIL startup_rise got=%b%b/%0d exp=11/0", bus_a.core_rst, bus_a.running,
               bus_a.cycle_cnt);
    end
    checks++;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (bus_a.cycle_cnt !== 32'(i)) begin
        failures++;
        $display("FAIL startup_count got=%0d exp=%0d", bus_a.cycle_cnt, i);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid_run();
    #2;
    rst_n = 1'b0;
    #1;
    if (bus_a.core_rst !== 1'b0 || bus_a.running !== 1'b0 || bus_a.cycle_cnt !== 32'd0 ||
        bus_a.instr_cnt !== 32'd0 || bus_a.trace_pc !== 16'h0000) begin
      failures++;
      $display("FAIL midrun_reset got=%b%b/%0d/%0d/%h exp=00/0/0/0000", bus_a.core_rst,
               bus_a.running, bus_a.cycle_cnt, bus_a.instr_cnt, bus_a.trace_pc);
    end
    checks++;
    step();
    rst_n = 1'b1;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    repeat (3) step();
    if (bus_a.core_rst !== 1'b0) begin
      failures++;
      $display("FAIL rerun_still_low got=%b exp=0", bus_a.core_rst);
    end
    checks++;
    step();
    if (bus_a.core_rst !== 1'b1 || bus_a.running !== 1'b1) begin
      failures++;
      $display("FAIL rerun_rise got=%b%b exp=11", bus_a.core_rst, bus_a.running);
    end
    checks++;
    bus_a.ir = 16'hF025;
    bus_a.ir_ld = 1'b1;
    step();
    bus_a.ir_ld = 1'b0;
  endtask

  task automatic test_halt_run();
    start_a();
    for (int i = 0; i < 4; i++) begin
      bus_a.ir = 16'h1021;
      bus_a.ir_ld = 1'b1;
      step();
      bus_a.ir_ld = 1'b0;
      bus_a.start = (i == 1);
      step();
      bus_a.start = 1'b0;
    end
    if (bus_a.running !== 1'b1 || bus_a.cycle_cnt !== 32'd8 || bus_a.instr_cnt !== 32'd4) begin
      failures++;
      $display("FAIL halt_pre got=%b/%0d/%0d exp=1/8/4", bus_a.running, bus_a.cycle_cnt,
               bus_a.instr_cnt);
    end
    checks++;
    bus_a.ir = 16'hF025;
    bus_a.ir_ld = 1'b1;
    step();
    if (bus_a.halted !== 1'b1 || bus_a.timeout !== 1'b0 || bus_a.core_rst !== 1'b0 ||
        bus_a.running !== 1'b0 || bus_a.instr_cnt !== 32'd5 || bus_a.cycle_cnt !== 32'd9) begin
      failures++;
      $display("FAIL halt_hit got=%b%b%b%b/%0d/%0d exp=1000/5/9", bus_a.halted, bus_a.timeout,
               bus_a.core_rst, bus_a.running, bus_a.instr_cnt, bus_a.cycle_cnt);
    end
    checks++;
    bus_a.ir = 16'h1021;
    repeat (3) step();
    bus_a.ir_ld = 1'b0;
    if (bus_a.halted !== 1'b1 || bus_a.instr_cnt !== 32'd5 || bus_a.cycle_cnt !== 32'd9) begin
      failures++;
      $display("FAIL halt_frozen got=%b/%0d/%0d exp=1/5/9", bus_a.halted, bus_a.instr_cnt,
               bus_a.cycle_cnt);
    end
    checks++;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    if (bus_a.halted !== 1'b0 || bus_a.cycle_cnt !== 32'd0 || bus_a.instr_cnt !== 32'd0 ||
        bus_a.core_rst !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear got=%b/%0d/%0d/%b exp=0/0/0/0", bus_a.halted,
               bus_a.cycle_cnt, bus_a.instr_cnt, bus_a.core_rst);
    end
    checks++;
    repeat (4) step();
    if (bus_a.running !== 1'b1) begin
      failures++;
      $display("FAIL restart_run got=%b exp=1", bus_a.running);
    end
    checks++;
    bus_a.ir = 16'hF025;
    bus_a.ir_ld = 1'b1;
    step();
    bus_a.ir_ld = 1'b0;
  endtask

  task automatic test_watchdog();
    int edges;
    start_a();
    edges = 0;
    while (bus_a.timeout !== 1'b1 && edges < 40) begin
      step();
      edges++;
    end
    if (edges !== 20) begin
      failures++;
      $display("FAIL wd_edges got=%0d exp=20", edges);
    end
    checks++;
    if (bus_a.timeout !== 1'b1 || bus_a.halted !== 1'b0 || bus_a.cycle_cnt !== 32'd20 ||
        bus_a.running !== 1'b0 || bus_a.core_rst !== 1'b0) begin
      failures++;
      $display("FAIL wd_state got=%b%b/%0d/%b%b exp=10/20/00", bus_a.timeout, bus_a.halted,
               bus_a.cycle_cnt, bus_a.running, bus_a.core_rst);
    end
    checks++;
  endtask

  task automatic test_halt_vs_watchdog();
    start_a();
    repeat (19) step();
    bus_a.ir = 16'hF025;
    bus_a.ir_ld = 1'b1;
    step();
    bus_a.ir_ld = 1'b0;
    if (bus_a.halted !== 1'b1 || bus_a.timeout !== 1'b0 || bus_a.cycle_cnt !== 32'd20 ||
        bus_a.instr_cnt !== 32'd1) begin
      failures++;
      $display("FAIL halt_wins got=%b%b/%0d/%0d exp=10/20/1", bus_a.halted, bus_a.timeout,
               bus_a.cycle_cnt, bus_a.instr_cnt);
    end
    checks++;
  endtask

  task automatic test_trace();
    logic [15:0] exp_pc [4];
    start_a();
    for (int i = 0; i < 5; i++) begin
      bus_a.pc = 16'h3000 + 16'(i);
      bus_a.ir = 16'h1021;
      bus_a.ir_ld = 1'b1;
      step();
    end
    bus_a.ir_ld = 1'b0;
`ifdef LC3_TRACE_EN
    exp_pc[0] = 16'h3004; exp_pc[1] = 16'h3003; exp_pc[2] = 16'h3002; exp_pc[3] = 16'h3001;
`else
    exp_pc[0] = 16'h0; exp_pc[1] = 16'h0; exp_pc[2] = 16'h0; exp_pc[3] = 16'h0;
`endif
    for (int i = 0; i < 4; i++) begin
      bus_a.trace_idx = 2'(i);
      #1;
      if (bus_a.trace_pc !== exp_pc[i]) begin
        failures++;
        $display("FAIL trace_full[%0d] got=%h exp=%h", i, bus_a.trace_pc, exp_pc[i]);
      end
      checks++;
    end
    bus_a.pc = 16'h3005;
    bus_a.ir = 16'hF025;
    bus_a.ir_ld = 1'b1;
    step();
    bus_a.ir_ld = 1'b0;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    bus_a.trace_idx = 2'd0;
    #1;
    if (bus_a.trace_pc !== 16'h0000) begin
      failures++;
      $display("FAIL trace_cleared got=%h exp=0000", bus_a.trace_pc);
    end
    checks++;
    step();
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      bus_a.pc = 16'h4000 + 16'(i);
      bus_a.ir = 16'h1021;
      bus_a.ir_ld = 1'b1;
      step();
    end
    bus_a.ir_ld = 1'b0;
`ifdef LC3_TRACE_EN
    exp_pc[0] = 16'h4001; exp_pc[1] = 16'h4000; exp_pc[2] = 16'h0; exp_pc[3] = 16'h0;
`else
    exp_pc[0] = 16'h0; exp_pc[1] = 16'h0; exp_pc[2] = 16'h0; exp_pc[3] = 16'h0;
`endif
    for (int i = 0; i < 4; i++) begin
      bus_a.trace_idx = 2'(3 - i);
      #1;
      if (bus_a.trace_pc !== exp_pc[3 - i]) begin
        failures++;
        $display("FAIL trace_partial[%0d] got=%h exp=%h", 3 - i, bus_a.trace_pc, exp_pc[3 - i]);
      end
      checks++;
    end
    if (bus_a.instr_cnt !== 32'd2) begin
      failures++;
      $display("FAIL trace_instr got=%0d exp=2", bus_a.instr_cnt);
    end
    checks++;
  endtask

  task automatic test_saturate();
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    repeat (2) step();
    if (bus_b.running !== 1'b1 || bus_b.cycle_cnt !== 4'd0) begin
      failures++;
      $display("FAIL sat_enter got=%b/%0d exp=1/0", bus_b.running, bus_b.cycle_cnt);
    end
    checks++;
    bus_b.ir = 16'h1021;
    bus_b.ir_ld = 1'b1;
    repeat (15) step();
    if (bus_b.cycle_cnt !== 4'd15 || bus_b.instr_cnt !== 4'd15) begin
      failures++;
      $display("FAIL sat_at15 got=%0d/%0d exp=15/15", bus_b.cycle_cnt, bus_b.instr_cnt);
    end
    checks++;
    repeat (5) step();
    bus_b.ir_ld = 1'b0;
    if (bus_b.cycle_cnt !== 4'd15 || bus_b.instr_cnt !== 4'd15 || bus_b.running !== 1'b1 ||
        bus_b.timeout !== 1'b0) begin
      failures++;
      $display("FAIL sat_hold got=%0d/%0d/%b%b exp=15/15/10", bus_b.cycle_cnt,
               bus_b.instr_cnt, bus_b.running, bus_b.timeout);
    end
    checks++;
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.ir_ld = 1'b0; bus_a.ir = 16'h0; bus_a.pc = 16'h0;
    bus_a.trace_idx = '0;
    bus_b.start = 1'b0; bus_b.ir_ld = 1'b0; bus_b.ir = 16'h0; bus_b.pc = 16'h0;
    bus_b.trace_idx = '0;
    repeat (2) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_startup();
    test_reset_mid_run();
    test_halt_run();
    test_watchdog();
    test_halt_vs_watchdog();
    test_trace();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lc3_run_ctrl.md
# lc3_run_ctrl

Synthesizable run controller that wraps `lc3_datapath` and replaces ad-hoc testbench sequencing with a parametrised reset sequencer, halt detector, cycle/instruction counters and watchdog. Sits between the board/bench clock-reset and the datapath: it drives the core's reset and observes the datapath's IR load strobe, IR and PC. Lets benches and FPGA builds start, run to `HALT`, and read back run statistics without hierarchical peeks.

## Interface
- `RST_CYCLES`, 4: cycles the core reset is held low after `start`; must be ≥1.
- `TIMEOUT_CYCLES`, 100000: RUN-state cycle limit; 0 disables the watchdog.
- `CNT_W`, 32: width of both counters.
- `TRACE_DEPTH`, 8: PC trace entries; power of 2, ≥2.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE and DONE.
- `ir_ld`  in  1  datapath IR load strobe (one instruction fetched).
- `ir`  in  16  value being loaded into IR when `ir_ld`=1.
- `pc`  in  16  PC of the instruction being loaded when `ir_ld`=1.
- `trace_idx`  in  log2(TRACE_DEPTH)  trace read index; 0 = most recent.
- `core_rst`  out  1  active-low reset to `lc3_datapath`, registered.
- `running`  out  1  high in RUN.
- `halted`  out  1  sticky: run ended on `HALT`.
- `timeout`  out  1  sticky: run ended on watchdog.
- `cycle_cnt`  out  CNT_W  RUN cycles completed.
- `instr_cnt`  out  CNT_W  instructions fetched in RUN.
- `trace_pc`  out  16  PC at `trace_idx`, combinational.

## Operation
- States: IDLE, RESET, RUN, DONE. `rst`=0 forces IDLE immediately; all outputs 0, counters 0, trace cleared.
- IDLE: `core_rst`=0. `start`=1 → RESET; counters, `halted`, `timeout`, trace cleared on that edge.
- RESET: `core_rst`=0; down-counter loaded with RST_CYCLES-1; at 0 → RUN.
- RUN: `core_rst`=1, `running`=1. `cycle_cnt`+1 every cycle; `instr_cnt`+1 on `ir_ld`. Both saturate at all-ones.
- Halt: `ir_ld`=1 and `ir`=16'hF025 → DONE, `halted`=1; the HALT is counted in `instr_cnt` and traced.
- Watchdog: TIMEOUT_CYCLES≠0 and `cycle_cnt`=TIMEOUT_CYCLES-1 in RUN → DONE, `timeout`=1.
- Halt and watchdog in the same cycle: halt wins, `timeout` stays 0.
- DONE: `core_rst`=0 (core frozen), counters and flags hold. `start`=1 → RESET (same clear as from IDLE).
- `start` in RESET or RUN ignored. `ir_ld` outside RUN ignored.

## Timing
- `start` sampled at edge N → RESET from N; `core_rst` rises at edge N+RST_CYCLES, together with `running`.
- Core sees exactly RST_CYCLES low cycles of `core_rst` per run.
- Counters and flags update on the edge that samples the event; halt/watchdog edge also drops `core_rst` and `running`.
- After HALT on edge M: `core_rst`=0 from M; no further counting.
- `rst` deassertion: first `start` accepted on the following edge.

## Configuration
- `LC3_TRACE_EN` defined: TRACE_DEPTH×16 circular PC buffer; each RUN `ir_ld` writes `pc` at the write pointer, which wraps modulo TRACE_DEPTH; `trace_pc` returns the entry `trace_idx` fetches back, 0 if fewer than `trace_idx`+1 entries were written since the last clear.
- Not defined: no buffer or pointer logic, `trace_pc` tied to 16'h0000, `trace_idx` unused.

## Test plan
- `rst`=0 mid-RUN → all outputs 0, state IDLE same cycle; `start` after release → normal run.
- RST_CYCLES=4, `start` at edge 10 → `core_rst` low edges 10–13, high from edge 14, `running`=1, `cycle_cnt` counts 1,2,3…
- 5 `ir_ld` pulses, fifth with `ir`=F025 → `halted`=1, `instr_cnt`=5, `core_rst`=0, counters frozen, `start` ignored until DONE then restarts with counters 0.
- TIMEOUT_CYCLES=20, no HALT → `timeout`=1, `cycle_cnt`=20, `halted`=0; HALT on the 20th cycle → `halted`=1, `timeout`=0.
- `LC3_TRACE_EN`, TRACE_DEPTH=4, PCs 3000,3001,3002,3003,3004 fetched → `trace_idx` 0..3 read 3004,3003,3002,3001; after 2 fetches `trace_idx`=3 reads 0.
- CNT_W=4, TIMEOUT_CYCLES=0, 20 RUN cycles → `cycle_cnt` saturates at 15.
